fpu_mul_arbiter: RTL

FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

---
 rtl/fpu_mul_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/fpu_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_mul_arbiter
//   Shares one combinational single-precision multiplier between two
//   requesters. A round-robin arbiter grants one operand pair at a time. The
//   pair is held in internal registers for EXEC_CYCLES cycles, then the product
//   and its flags are captured into a response register. That response is
//   held until the consumer takes it.
//
//   Multiplier behaviour (fpu_mul_core):
//     - round to nearest, ties to even
//     - denormal inputs are treated as zero
//     - a finite result whose rounded exponent is below the normal range is
//       flushed to signed zero and raises underflow
//     - a result that rounds beyond the largest finite value becomes signed
//       infinity and raises overflow
//     - NaN in, or inf * 0, gives the quiet NaN 0x7FC00000
//     - inf * finite gives signed infinity with no flags raised
//
// Parameters
//   EXEC_CYCLES  cycles operands sit at the multiplier before capture (1..15)
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req{0,1}_valid/_ready/_a/_b     requester handshakes and IEEE-754 operands
//   rsp_valid/rsp_ready             response handshake
//   rsp_id                          requester that owns the response
//   rsp_result/_overflow/_underflow registered product and flags
//   busy                            FSM is not idle
// ---------------------------------------------------------------------------

module fpu_mul_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic        sign;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sign = a[31] ^ b[31];
  assign ea   = a[30:23];
  assign eb   = b[30:23];
  assign fa   = a[22:0];
  assign fb   = b[22:0];

  // An exponent field of zero covers both true zero and denormals.
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  logic [47:0]        prod;
  logic signed [10:0] e_pre, e_norm, e_rnd;
  logic [23:0]        mant;
  logic               guard, sticky, round_up;
  logic [24:0]        mant_rnd;

  // Both significands lie in [1,2), so the product lies in [1,4).
  assign prod = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};

  always_comb begin
    e_pre = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      e_norm = e_pre + 11'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      e_norm = e_pre;
    end
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {24'd0, round_up};
    // When rounding carries out, the significand is exactly 2.0. The fraction
    // bits are already zero, so only the exponent needs a bump.
    e_rnd    = mant_rnd[24] ? e_norm + 11'sd1 : e_norm;

    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      result = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      result = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      result = {sign, 31'd0};
    end else if (e_rnd >= 11'sd255) begin
      result   = {sign, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (e_rnd <= 11'sd0) begin
      result    = {sign, 31'd0};
      underflow = 1'b1;
    end else begin
      result = {sign, e_rnd[7:0], mant_rnd[22:0]};
    end
  end

endmodule

module fpu_mul_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_grant;
  logic [31:0] op_a, op_b;
  logic        op_id;
  logic        grant_vld, grant_id;

  logic [31:0] mul_result;
  logic        mul_ovf, mul_unf;

  // The multiplier only ever sees the operand registers. Requesters may
  // change their inputs freely once they have been accepted.
  fpu_mul_core u_mul (
    .a         (op_a),
    .b         (op_b),
    .result    (mul_result),
    .overflow  (mul_ovf),
    .underflow (mul_unf)
  );

  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_vld = 1'b1;
          // On a tie, the requester that was not granted last wins.
          // Otherwise, whichever requester is valid wins.
          grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: if (cnt == 4'd0) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 4'd0;
      last_grant    <= 1'b1;   // requester 0 wins the first tie
      op_a          <= '0;
      op_b          <= '0;
      op_id         <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
    end else begin
      if (grant_vld) begin
        op_a       <= grant_id ? req1_a : req0_a;
        op_b       <= grant_id ? req1_b : req0_b;
        op_id      <= grant_id;
        last_grant <= grant_id;
        cnt        <= CNT_INIT;
      end
      if (state == EXEC) begin
        if (cnt == 4'd0) begin
          rsp_id        <= op_id;
          rsp_result    <= mul_result;
          rsp_overflow  <= mul_ovf;
          rsp_underflow <= mul_unf;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
